// File: rtl/ack_response_queue_if.sv
// ---------------------------------------------------------------------------
// types: flit format shared by the ACK queue, its interface and its bench.
//   header_t : is_ack, src_id, dst_id, flit_id
//   flit_t   : header, 16-bit payload, 8-bit checksum
//   The checksum is the XOR of the five bytes of {7'b0, header, payload}.
//   make_ack_comb turns a data flit into its ACK: src/dst swapped, is_ack
//   set, payload kept, checksum recomputed.
//
// ack_response_queue_if: flit input and ACK output handshakes.
//   flit_in / flit_in_valid / flit_in_ready : incoming flits
//   ack_out / ack_out_valid / ack_out_ready : queued ACK flits
//   slave modport  = the queue, master modport = its environment.
//   Both channels are valid/ready: a transfer happens on a rising clock edge
//   where valid and ready are both high. A valid producer holds its data
//   stable until the transfer happens.
// ---------------------------------------------------------------------------
package types;
    typedef logic [3:0] node_id_t;
    typedef logic [7:0] flit_id_t;

    typedef struct packed {
        logic     is_ack;
        node_id_t src_id;
        node_id_t dst_id;
        flit_id_t flit_id;
    } header_t;

    typedef struct packed {
        header_t     header;
        logic [15:0] payload;
        logic [7:0]  checksum;
    } flit_t;

    function automatic logic [7:0] calc_checksum(input header_t h, input logic [15:0] p);
        logic [39:0] bits;
        bits = {7'd0, h, p};
        return bits[39:32] ^ bits[31:24] ^ bits[23:16] ^ bits[15:8] ^ bits[7:0];
    endfunction

    function automatic flit_t make_ack_comb(input flit_t f);
        flit_t a;
        a                = f;
        a.header.is_ack  = 1'b1;
        a.header.src_id  = f.header.dst_id;
        a.header.dst_id  = f.header.src_id;
        a.checksum       = calc_checksum(a.header, a.payload);
        return a;
    endfunction
endpackage

interface ack_response_queue_if;
    types::flit_t flit_in;
    logic         flit_in_valid;
    logic         flit_in_ready;
    types::flit_t ack_out;
    logic         ack_out_valid;
    logic         ack_out_ready;

    modport slave (
        input  flit_in, flit_in_valid, ack_out_ready,
        output flit_in_ready, ack_out, ack_out_valid
    );

    modport master (
        output flit_in, flit_in_valid, ack_out_ready,
        input  flit_in_ready, ack_out, ack_out_valid
    );
endinterface

// File: rtl/ack_response_queue.sv
// ---------------------------------------------------------------------------
// ack_response_queue: turns data flits addressed to this node into ACK flits
// and queues them (DEPTH-entry FIFO) for the TX arbiter. Back-to-back
// retransmissions of the same {src_id, flit_id} are dropped.
//
// Ports
//   clk, rst      : clock, synchronous active-high reset
//   this_node_id  : ID of this node
//   bus (slave)   : flit_in / ack_out valid/ready channels
//   ack_count     : ACKs enqueued since reset (wraps)
//   drop_count    : eligible flits dropped as duplicates (wraps)
// ---------------------------------------------------------------------------
module ack_response_queue #(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  types::node_id_t      this_node_id,
    ack_response_queue_if.slave  bus,
    output logic [CNT_WIDTH-1:0] ack_count,
    output logic [CNT_WIDTH-1:0] drop_count
);
    localparam int            PW       = $clog2(DEPTH);
    localparam int            KW       = $bits(types::node_id_t) + $bits(types::flit_id_t);
    localparam logic [PW:0]   OCC_FULL = (PW+1)'(DEPTH);

    types::flit_t         mem_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW:0]          occ_q, occ_d;
    logic [CNT_WIDTH-1:0] ack_cnt_q, ack_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [KW-1:0]        last_key_q, last_key_d;
    logic                 last_key_vld_q, last_key_vld_d;

    logic                 accept;
    logic                 pop;
    logic                 eligible;
    logic                 dup;
    logic                 push;
    logic [KW-1:0]        in_key;
    types::flit_t         ack_flit;

    // Ready depends only on rst and registered occupancy: a pop in the
    // full cycle does not open the input until the next cycle.
    assign bus.flit_in_ready = !rst && (occ_q != OCC_FULL);
    assign bus.ack_out_valid = (occ_q != '0);
    assign bus.ack_out       = mem_q[rd_ptr_q];

    assign accept   = bus.flit_in_valid && bus.flit_in_ready;
    assign pop      = bus.ack_out_valid && bus.ack_out_ready;
    assign eligible = accept && !bus.flit_in.header.is_ack
                      && (bus.flit_in.header.dst_id == this_node_id);
    assign in_key   = {bus.flit_in.header.src_id, bus.flit_in.header.flit_id};
    assign dup      = eligible && last_key_vld_q && (in_key == last_key_q);
    assign push     = eligible && !dup;
    assign ack_flit = types::make_ack_comb(bus.flit_in);

    assign ack_count  = ack_cnt_q;
    assign drop_count = drop_cnt_q;

    always_comb begin
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        occ_d          = occ_q;
        ack_cnt_d      = ack_cnt_q;
        drop_cnt_d     = drop_cnt_q;
        last_key_d     = last_key_q;
        last_key_vld_d = last_key_vld_q;

        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            ack_cnt_d = ack_cnt_q + CNT_WIDTH'(1);
        end
        if (dup) begin
            drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
        // History follows every eligible flit, duplicates included.
        if (eligible) begin
            last_key_d     = in_key;
            last_key_vld_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + (PW+1)'(1);
            2'b01:   occ_d = occ_q - (PW+1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            occ_q          <= '0;
            ack_cnt_q      <= '0;
            drop_cnt_q     <= '0;
            last_key_q     <= '0;
            last_key_vld_q <= 1'b0;
        end else begin
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            occ_q          <= occ_d;
            ack_cnt_q      <= ack_cnt_d;
            drop_cnt_q     <= drop_cnt_d;
            last_key_q     <= last_key_d;
            last_key_vld_q <= last_key_vld_d;
        end
    end

    // Storage needs no reset: entries are only read while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ack_flit;
        end
    end
endmodule

// File: tb/tb_ack_response_queue.sv
module tb_ack_response_queue;
    import types::*;

    localparam int DEPTH = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    node_id_t      node;
    logic [CW-1:0] ack_count;
    logic [CW-1:0] drop_count;

    ack_response_queue_if bus();

    ack_response_queue #(.DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .this_node_id (node),
        .bus          (bus),
        .ack_count    (ack_count),
        .drop_count   (drop_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int    n_checks = 0;
    int    n_pass   = 0;
    flit_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] ref_cs(input logic [16:0] hdr, input logic [15:0] pl);
        logic [39:0] w;
        logic [7:0]  cs;
        w  = {7'd0, hdr, pl};
        cs = 8'd0;
        for (int i = 0; i < 5; i++) cs = cs ^ w[8*i +: 8];
        return cs;
    endfunction

    function automatic flit_t data_flit(input logic is_ack, input node_id_t src,
                                        input node_id_t dst, input flit_id_t id);
        flit_t f;
        f.header.is_ack  = is_ack;
        f.header.src_id  = src;
        f.header.dst_id  = dst;
        f.header.flit_id = id;
        f.payload        = {4'hA, src, id};
        f.checksum       = ref_cs({is_ack, src, dst, id}, f.payload);
        return f;
    endfunction

    // ACK expected for a data flit from orig_src accepted by node 'me'.
    function automatic flit_t exp_ack(input node_id_t me, input node_id_t orig_src, input flit_id_t id);
        flit_t f;
        f.header.is_ack  = 1'b1;
        f.header.src_id  = me;
        f.header.dst_id  = orig_src;
        f.header.flit_id = id;
        f.payload        = {4'hA, orig_src, id};
        f.checksum       = ref_cs({1'b1, me, orig_src, id}, f.payload);
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    // Called right after a negedge with inputs already driven; samples the
    // handshakes before the posedge and returns at the following negedge.
    task automatic do_cycle(input logic expect_ack, input flit_t exp_f, output logic acc);
        flit_t e;
        #1;
        if (bus.ack_out_valid && bus.ack_out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pop", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_order", bus.ack_out, e);
            end
        end
        acc = bus.flit_in_valid && bus.flit_in_ready;
        if (acc && expect_ack) exp_q.push_back(exp_f);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst               = 1'b1;
        bus.flit_in_valid = 1'b0;
        bus.ack_out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", bus.flit_in_ready, 0);
        check("rst_out_valid", bus.ack_out_valid, 0);
        check("rst_ack_count", ack_count, 0);
        check("rst_drop_count", drop_count, 0);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_release_ready", bus.flit_in_ready, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic     in_v;
        logic     is_ack;
        node_id_t nd;
        node_id_t src;
        node_id_t dst;
        flit_id_t id;
        logic     out_rdy;
        logic     e_valid;
        node_id_t e_hsrc;
        node_id_t e_hdst;
        flit_id_t e_hid;
        logic [CW-1:0] e_ack;
        logic [CW-1:0] e_drop;
        logic     e_ready;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic in_v, input logic is_ack, input node_id_t nd,
                       input node_id_t src, input node_id_t dst, input flit_id_t id,
                       input logic out_rdy, input logic e_valid, input node_id_t e_hsrc,
                       input node_id_t e_hdst, input flit_id_t e_hid,
                       input logic [CW-1:0] e_ack, input logic [CW-1:0] e_drop, input logic e_ready);
        vec_t v;
        v.in_v = in_v; v.is_ack = is_ack; v.nd = nd; v.src = src; v.dst = dst; v.id = id;
        v.out_rdy = out_rdy; v.e_valid = e_valid; v.e_hsrc = e_hsrc; v.e_hdst = e_hdst;
        v.e_hid = e_hid; v.e_ack = e_ack; v.e_drop = e_drop; v.e_ready = e_ready;
        tv.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic acc;
        int   acc_cycle;
        int   pops;
        flit_t dummy;

        dummy             = '0;
        rst               = 1'b1;
        node              = 4'd3;
        bus.flit_in       = '0;
        bus.flit_in_valid = 1'b0;
        bus.ack_out_ready = 1'b0;

        //   v  ack node src dst id     rdy  | valid hsrc hdst hid  ack  drop ready
        // T1 basic, then pop it
        add(1'b1, 1'b0, 4'd3, 4'd1, 4'd3, 8'd5, 1'b0, 1'b1, 4'd3, 4'd1, 8'd5, 16'd1, 16'd0, 1'b1);
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd1, 16'd0, 1'b1);
        // T2 filter: wrong destination, then an ACK flit
        add(1'b1, 1'b0, 4'd3, 4'd1, 4'd7, 8'd9, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 16'd1, 16'd0, 1'b1);
        add(1'b1, 1'b1, 4'd3, 4'd2, 4'd3, 8'd9, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 16'd1, 16'd0, 1'b1);
        // T3 dedup: history still holds (1,5) since filtered flits leave it alone
        add(1'b1, 1'b0, 4'd3, 4'd1, 4'd3, 8'd5, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 16'd1, 16'd1, 1'b1);
        add(1'b1, 1'b0, 4'd3, 4'd1, 4'd3, 8'd5, 1'b0, 1'b0, 4'd0, 4'd0, 8'd0, 16'd1, 16'd2, 1'b1);
        add(1'b1, 1'b0, 4'd3, 4'd2, 4'd3, 8'd5, 1'b0, 1'b1, 4'd3, 4'd2, 8'd5, 16'd2, 16'd2, 1'b1);
        add(1'b1, 1'b0, 4'd3, 4'd1, 4'd3, 8'd5, 1'b0, 1'b1, 4'd3, 4'd2, 8'd5, 16'd3, 16'd2, 1'b1);
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b1, 4'd3, 4'd1, 8'd5, 16'd3, 16'd2, 1'b1);
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd3, 16'd2, 1'b1);
        // empty: ready ignored, no underflow; push into empty while ready=1
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd3, 16'd2, 1'b1);
        add(1'b1, 1'b0, 4'd3, 4'd4, 4'd3, 8'd6, 1'b1, 1'b1, 4'd3, 4'd4, 8'd6, 16'd4, 16'd2, 1'b1);
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b0, 1'b1, 4'd3, 4'd4, 8'd6, 16'd4, 16'd2, 1'b1);
        // node ID change: old destination no longer eligible, new one is
        add(1'b1, 1'b0, 4'd5, 4'd4, 4'd3, 8'd7, 1'b0, 1'b1, 4'd3, 4'd4, 8'd6, 16'd4, 16'd2, 1'b1);
        add(1'b1, 1'b0, 4'd5, 4'd4, 4'd5, 8'd7, 1'b1, 1'b1, 4'd5, 4'd4, 8'd7, 16'd5, 16'd2, 1'b1);
        add(1'b0, 1'b0, 4'd3, 4'd0, 4'd0, 8'd0, 1'b1, 1'b0, 4'd0, 4'd0, 8'd0, 16'd5, 16'd2, 1'b1);

        // reset phase
        @(negedge clk);
        @(negedge clk);
        check("init_in_ready", bus.flit_in_ready, 0);
        check("init_out_valid", bus.ack_out_valid, 0);
        check("init_ack_count", ack_count, 0);
        check("init_drop_count", drop_count, 0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            node              = tv[i].nd;
            bus.flit_in       = data_flit(tv[i].is_ack, tv[i].src, tv[i].dst, tv[i].id);
            bus.flit_in_valid = tv[i].in_v;
            bus.ack_out_ready = tv[i].out_rdy;
            @(negedge clk);
            check($sformatf("v%0d_valid", i), bus.ack_out_valid, tv[i].e_valid);
            check($sformatf("v%0d_ack_count", i), ack_count, tv[i].e_ack);
            check($sformatf("v%0d_drop_count", i), drop_count, tv[i].e_drop);
            check($sformatf("v%0d_in_ready", i), bus.flit_in_ready, tv[i].e_ready);
            if (tv[i].e_valid)
                check($sformatf("v%0d_ack_out", i), bus.ack_out,
                      exp_ack(tv[i].e_hsrc, tv[i].e_hdst, tv[i].e_hid));
            if (i == 0)
                check("t1_literal_ack", bus.ack_out, 64'h13105A10591);
        end
        bus.flit_in_valid = 1'b0;
        node              = 4'd3;

        // T4 full
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.flit_in       = data_flit(1'b0, 4'd1, 4'd3, 8'(10 + k));
            bus.flit_in_valid = 1'b1;
            do_cycle(1'b1, exp_ack(4'd3, 4'd1, 8'(10 + k)), acc);
            check("t4_accept", acc, 1);
        end
        bus.flit_in = data_flit(1'b0, 4'd1, 4'd3, 8'd14);
        #1;
        check("t4_full_ready", bus.flit_in_ready, 0);
        do_cycle(1'b1, exp_ack(4'd3, 4'd1, 8'd14), acc);
        check("t4_fifth_held", acc, 0);
        bus.ack_out_ready = 1'b1;
        #1;
        check("t4_full_pop_ready", bus.flit_in_ready, 0);
        acc_cycle = 0;
        for (int c = 1; c <= 6; c++) begin
            do_cycle(1'b1, exp_ack(4'd3, 4'd1, 8'd14), acc);
            if (acc) begin
                acc_cycle = c;
                break;
            end
        end
        check("t4_fifth_accept_cycle", acc_cycle, 2);
        bus.flit_in_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (exp_q.size() == 0) break;
            do_cycle(1'b0, dummy, acc);
        end
        check("t4_drained", exp_q.size(), 0);
        #1;
        check("t4_empty_valid", bus.ack_out_valid, 0);
        check("t4_ack_count", ack_count, 5);
        check("t4_drop_count", drop_count, 0);
        @(negedge clk);

        // T5 simultaneous push and pop at occupancy 2
        bus.ack_out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.flit_in       = data_flit(1'b0, 4'd2, 4'd3, 8'(20 + k));
            bus.flit_in_valid = 1'b1;
            do_cycle(1'b1, exp_ack(4'd3, 4'd2, 8'(20 + k)), acc);
            check("t5_fill", acc, 1);
        end
        bus.ack_out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.flit_in = data_flit(1'b0, 4'd2, 4'd3, 8'(22 + k));
            do_cycle(1'b1, exp_ack(4'd3, 4'd2, 8'(22 + k)), acc);
            check("t5_accept", acc, 1);
        end
        bus.flit_in_valid = 1'b0;
        pops = 0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (!bus.ack_out_valid) break;
            pops++;
            do_cycle(1'b0, dummy, acc);
        end
        check("t5_occupancy_left", pops, 2);
        check("t5_sb_empty", exp_q.size(), 0);
        check("t5_ack_count", ack_count, 17);
        @(negedge clk);

        // T6 reset with ACKs queued
        bus.ack_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.flit_in       = data_flit(1'b0, 4'd6, 4'd3, 8'(30 + k));
            bus.flit_in_valid = 1'b1;
            do_cycle(1'b1, exp_ack(4'd3, 4'd6, 8'(30 + k)), acc);
            check("t6_fill", acc, 1);
        end
        #1;
        check("t6_queued_valid", bus.ack_out_valid, 1);
        do_reset();
        bus.flit_in       = data_flit(1'b0, 4'd6, 4'd3, 8'd32);
        bus.flit_in_valid = 1'b1;
        do_cycle(1'b1, exp_ack(4'd3, 4'd6, 8'd32), acc);
        check("t6_resend_accept", acc, 1);
        bus.flit_in_valid = 1'b0;
        #1;
        check("t6_resend_valid", bus.ack_out_valid, 1);
        check("t6_ack_count", ack_count, 1);
        check("t6_drop_count", drop_count, 0);
        @(negedge clk);
        bus.ack_out_ready = 1'b1;
        do_cycle(1'b0, dummy, acc);
        check("t6_sb_empty", exp_q.size(), 0);
        #1;
        check("t6_final_valid", bus.ack_out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
